// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and sign helpers for the mul/div unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // Helpers work on a wide carrier; callers zero-extend in and truncate out,
    // which keeps two's-complement negation exact at any width up to XW.
    localparam int XW = 128;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    function automatic logic [XW-1:0] neg_if(input logic [XW-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [XW-1:0] abs_val(input logic [XW-1:0] x, input logic is_neg);
        return neg_if(x, is_neg);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mips_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, divisor, dividend_orig;
    logic [PW-1:0]    acc;
    logic             neg_q, neg_r, is_div;

    logic             signed_op, rs_neg, rt_neg, last_iter, div_ge;
    logic [WIDTH-1:0] rs_abs, rt_abs, div_diff, quot_fix, rem_fix;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [PW-1:0]    prod_fix;

    assign busy      = (state != IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs_data[WIDTH-1];
    assign rt_neg    = signed_op & rt_data[WIDTH-1];
    assign rs_abs    = WIDTH'(abs_val(XW'(rs_data), rs_neg));
    assign rt_abs    = WIDTH'(abs_val(XW'(rt_data), rt_neg));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign div_trial = acc[PW-1:WIDTH-1];
    assign div_ge    = (div_trial >= {1'b0, divisor});
    assign div_diff  = div_trial[WIDTH-1:0] - divisor;

    assign prod_fix  = PW'(neg_if(XW'(acc), neg_q));
    assign quot_fix  = WIDTH'(neg_if(XW'(acc[WIDTH-1:0]), neg_q));
    assign rem_fix   = WIDTH'(neg_if(XW'(acc[PW-1:WIDTH]), neg_r));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = op[1] ? DIV : MUL;
            MUL, DIV: if (last_iter) state_next = FIX;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            mcand         <= '0;
            divisor       <= '0;
            dividend_orig <= '0;
            acc           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            is_div        <= 1'b0;
            hi            <= '0;
            lo            <= '0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div        <= op[1];
                        neg_q         <= rs_neg ^ rt_neg;
                        neg_r         <= rs_neg;
                        dividend_orig <= rs_data;
                        mcand         <= rs_abs;
                        divisor       <= rt_abs;
                        acc           <= {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
                        cnt           <= '0;
                        div_by_zero   <= 1'b0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[PW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (divisor == '0) begin
                        // Divide by zero: report the original dividend and an all-ones quotient.
                        hi          <= dividend_orig;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit
module tb_mips_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] rs_data, rt_data, wdata;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int           checks = 0;
    int           failures = 0;
    logic [31:0]  m_hi, m_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        bit          disturb;
        bit          lo_we_with_start;
    } vec_t;

    vec_t vecs[10];

    always #5 clock = ~clock;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        case (o)
            OP_MULT: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF; z = 1'b1;
                end else if (o == OP_DIV) begin
                    p = sa / sb; l = p[31:0];
                    p = sa % sb; h = p[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input bit disturb, input bit lo_with_start, input string name);
        int nb, lat;
        bit seen, held;
        op = o; rs_data = r1; rt_data = r2; start = 1'b1;
        hi_we = 1'b0; lo_we = lo_with_start; wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0; lo_we = 1'b0;
        nb = 0; lat = 0; seen = 0; held = 1;
        for (int k = 1; k <= 60 && !seen; k++) begin
            if (k == 1) chk({name, " dbz_cleared"}, 64'(div_by_zero), 64'd0);
            if (done) begin
                seen = 1;
                lat = k - 1;
            end else begin
                if (busy) nb++;
                if (hi !== m_hi || lo !== m_lo) held = 0;
                if (disturb && k == 5) begin
                    start = 1'b1; op = OP_DIVU; rs_data = 32'd99; rt_data = 32'd1;
                    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
                end else begin
                    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                end
                @(negedge clock);
            end
        end
        chk({name, " done_seen"}, 64'(seen), 64'd1);
        chk({name, " latency"}, 64'(lat), 64'(W + 1));
        chk({name, " busy_cycles"}, 64'(nb), 64'(W + 1));
        chk({name, " hilo_held"}, 64'(held), 64'd1);
        chk({name, " hi"}, 64'(hi), 64'(eh));
        chk({name, " lo"}, 64'(lo), 64'(el));
        chk({name, " dbz"}, 64'(div_by_zero), 64'(ed));
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;
        logic        ez;
        int          npulse;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1, 0};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0};
        vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 0, 0};
        vecs[4] = '{OP_DIVU,  32'd7,        32'd0,         32'd7,        32'hFFFF_FFFF, 1'b1, 0, 0};
        vecs[5] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,       32'h0,         1'b0, 0, 0};
        vecs[6] = '{OP_DIVU,  32'd100,      32'd7,         32'd2,        32'd14,        1'b0, 0, 1};
        vecs[7] = '{OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 0, 0};
        vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,       1'b0, 0, 0};
        vecs[9] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 0, 0};

        reset = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        m_hi = '0;
        m_lo = '0;

        // Each op starts in the done cycle of the previous one.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                   vecs[i].disturb, vecs[i].lo_we_with_start, $sformatf("vec%0d", i));

        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clock);
        hi_we = 1'b0;
        chk("mthi hi", 64'(hi), 64'h1234_5678);
        chk("mthi lo_kept", 64'(lo), 64'(m_lo));
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo hi", 64'(hi), 64'hA5A5_5A5A);
        chk("mthilo lo", 64'(lo), 64'hA5A5_5A5A);
        m_hi = 32'hA5A5_5A5A;
        m_lo = 32'hA5A5_5A5A;

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = ~32'($urandom_range(0, 9));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, eh, el, ez);
            run_op(ro, ra, rb, eh, el, ez, (i % 5) == 2, (i % 7) == 3, $sformatf("rand%0d", i));
        end

        op = OP_DIV; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) npulse++;
            @(negedge clock);
        end
        chk("midreset no_done", 64'(npulse), 64'd0);
        m_hi = '0;
        m_lo = '0;
        model(OP_MULTU, 32'h0000_1234, 32'h0000_5678, eh, el, ez);
        run_op(OP_MULTU, 32'h0000_1234, 32'h0000_5678, eh, el, ez, 0, 0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
